// File: rtl/sr_axis_pkg.sv
// sr_axis_pkg: shared AXI-Stream video types and defaults for the output side.
//   pixel_t        : one RGB888 pixel beat
//   beat_t         : {data, last (eol), user (sof)} as carried through the framer
//   framer_state_t : framer FSM encoding
package sr_axis_pkg;

    localparam int DATA_WIDTH_DEF     = 24;
    localparam int DST_IMG_WIDTH_DEF  = 3840;
    localparam int DST_IMG_HEIGHT_DEF = 2160;

    typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   last;
        logic   user;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } framer_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry skid buffer with a fully registered input ready.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_allow       : upstream may be accepted next cycle (owner's gating)
//   i_in_valid    : upstream valid        o_in_ready : registered upstream ready
//   i_in_data     : upstream payload
//   o_out_valid   : downstream valid      i_out_ready: downstream ready
//   o_out_data    : downstream payload (registered)
//   o_empty       : no entry remains once this cycle's pop completes
//                   (meaningful while no push is possible)
module axis_skid_buffer
    import sr_axis_pkg::*;
#(
    parameter int WIDTH = BEAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_allow,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_empty
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;
    logic             w_push;
    logic             w_skid_nxt;

    assign w_push = i_in_valid && r_in_ready;

    // Skid slot is occupied next cycle if it stays stalled, or if a push lands
    // on a stalled output register.
    assign w_skid_nxt = r_skid_valid ? !i_out_ready
                                     : (w_push && r_out_valid && !i_out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= i_allow && !w_skid_nxt;
            if (r_skid_valid) begin
                if (i_out_ready) begin
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_push) begin
                if (!r_out_valid || i_out_ready) begin
                    r_out_data  <= i_in_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_skid_data  <= i_in_data;
                    r_skid_valid <= 1'b1;
                end
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_empty     = !r_skid_valid && (!r_out_valid || i_out_ready);

endmodule

// File: rtl/axis_out_frame_framer.sv
// axis_out_frame_framer: counts pixels/lines of the upscaled output stream and
// re-emits it with tuser = start-of-frame and tlast = end-of-line through a
// 2-entry skid buffer. Armed by frame_start, reports completion on frame_done.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   frame_start             : arm pulse (honoured only in IDLE)
//   s_axis_*                : upstream pixels (tlast only used by the check)
//   m_axis_*                : downstream pixels with tlast/tuser sideband
//   busy, frame_done        : status to the config register file
//   err_tlast               : sticky upstream tlast mismatch flag
// Optional feature: FRAMER_TLAST_CHECK_EN enables the upstream tlast check;
// without it err_tlast is tied low.
//
// state | meaning
// IDLE  | waiting for frame_start, upstream held off
// RUN   | accepting and tagging beats of the current frame
// DRAIN | last beat accepted, waiting for the skid buffer to empty
module axis_out_frame_framer
    import sr_axis_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int DST_IMG_WIDTH  = DST_IMG_WIDTH_DEF,
    parameter int DST_IMG_HEIGHT = DST_IMG_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_tlast
);

    localparam int COL_W = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

    framer_state_t         r_state;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_frame_done;
    logic                  w_accept;
    logic                  w_sof;
    logic                  w_eol;
    logic                  w_frame_end;
    logic                  w_run_next;
    logic                  w_skid_empty;
    logic [DATA_WIDTH+1:0] w_in_beat;
    logic [DATA_WIDTH+1:0] w_out_beat;

    assign w_accept    = s_axis_tvalid && s_axis_tready;
    assign w_sof       = (r_col == '0) && (r_row == '0);
    assign w_eol       = (r_col == COL_LAST);
    assign w_frame_end = w_eol && (r_row == ROW_LAST);
    assign w_in_beat   = {s_axis_tdata, w_eol, w_sof};

    // Next-cycle RUN, so the skid buffer can register s_axis_tready directly.
    // An arm pulse landing on the frame_done cycle is deliberately refused.
    assign w_run_next = ((r_state == IDLE) && frame_start && !r_frame_done) ||
                        ((r_state == RUN) && !(w_accept && w_frame_end));

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 2)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_allow     (w_run_next),
        .i_in_valid  (s_axis_tvalid),
        .o_in_ready  (s_axis_tready),
        .i_in_data   (w_in_beat),
        .o_out_valid (m_axis_tvalid),
        .i_out_ready (m_axis_tready),
        .o_out_data  (w_out_beat),
        .o_empty     (w_skid_empty)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = w_out_beat;

`ifdef FRAMER_TLAST_CHECK_EN
    logic r_err_tlast;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
`ifdef FRAMER_TLAST_CHECK_EN
            r_err_tlast  <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start && !r_frame_done) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= RUN;
`ifdef FRAMER_TLAST_CHECK_EN
                        r_err_tlast <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (w_accept) begin
`ifdef FRAMER_TLAST_CHECK_EN
                        if (s_axis_tlast != w_eol) r_err_tlast <= 1'b1;
`endif
                        if (w_frame_end) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= DRAIN;
                        end else if (w_eol) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Upstream is closed here, so o_empty marks the final pop.
                    if (w_skid_empty) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
`ifdef FRAMER_TLAST_CHECK_EN
    assign err_tlast  = r_err_tlast;
`else
    assign err_tlast  = 1'b0;
`endif

endmodule

// File: doc/axis_out_frame_framer.md
# axis_out_frame_framer

Output-side framing stage placed directly downstream of the access-control block's master AXI-Stream port. It counts upscaled pixels per line and lines per frame, then re-emits the stream with AXI4-Stream video sideband: `tuser` marks start-of-frame and `tlast` marks end-of-line. It contains a 2-entry skid buffer so the DMA/VDMA sink sees a registered, full-throughput interface. It is armed by the UPSTART pulse from the config register file and reports frame completion back to it.

## Interface
- `DATA_WIDTH`, 24: pixel beat width, 3 × 8-bit RGB channels.
- `DST_IMG_WIDTH`, 3840: pixels per output line.
- `DST_IMG_HEIGHT`, 2160: lines per output frame.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: single-cycle arm pulse, driven by crf UPSTART.
- `s_axis_tvalid` in 1: upstream beat valid.
- `s_axis_tready` out 1: upstream ready.
- `s_axis_tdata` in DATA_WIDTH: upstream pixel.
- `s_axis_tlast` in 1: upstream last flag; used only by the check feature.
- `m_axis_tvalid` out 1: downstream valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out DATA_WIDTH: pixel.
- `m_axis_tlast` out 1: end-of-line.
- `m_axis_tuser` out 1: start-of-frame.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle pulse after the final beat leaves.
- `err_tlast` out 1: sticky tlast-mismatch flag (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE: `s_axis_tready`=0. On `frame_start`: clear `col` and `row`, clear `err_tlast`, go to RUN.
  - RUN: accept beats while the skid buffer has room. On accept of the beat with `row`=H-1 and `col`=W-1, go to DRAIN.
  - DRAIN: `s_axis_tready`=0. When the skid buffer is empty, pulse `frame_done` and go to IDLE.
- Tagging of each accepted beat:
  - `sof` = (`col`==0 && `row`==0).
  - `eol` = (`col`==W-1).
  - The tuple {data, eol, sof} is pushed into the skid buffer.
- Counters:
  - `col` is $clog2(W) bits and wraps to 0 at W-1; on wrap, `row` increments.
  - `row` is $clog2(H) bits.
  - No arithmetic overflow is possible: the frame ends at H-1/W-1.
- `frame_start` during RUN or DRAIN is ignored; it has no effect on counters or errors.
- Reset mid-frame (async `rst_n` low) returns the block to IDLE immediately, clears the counters, and empties the skid buffer. Partial-frame beats are lost; no `frame_done` is generated.
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `busy`=0, `frame_done`=0, `err_tlast`=0.

## Timing
- Latency: an input accepted at cycle N is presented on `m_axis_*` at cycle N+1 when the output register is empty or draining.
- Throughput: 1 beat/cycle sustained while `m_axis_tready`=1.
- `s_axis_tready` is a registered signal, equal to "skid slot empty" and state==RUN. A single stall cycle of `m_axis_tready` is absorbed without dropping a beat.
- Output stability: `m_axis_*` holds stable while `tvalid`=1 and `tready`=0. `tvalid` never deasserts without a handshake.
- Handshakes: simultaneous push and pop with the buffer holding 1 entry keeps the occupancy at 1. A push with the buffer full cannot occur, because `tready` is already 0.
- `frame_done` asserts the cycle after the final `m_axis` handshake; `busy` falls in the same cycle.
- `frame_start` coincident with `frame_done` (IDLE entry) is not accepted. Re-arming requires a pulse while in IDLE.

## Configuration
- `FRAMER_TLAST_CHECK_EN` defined:
  - On every accepted beat, compare `s_axis_tlast` with the computed `eol`.
  - A mismatch sets `err_tlast`, which stays set until the next accepted `frame_start` or reset.
  - Output tagging always uses the computed `eol`.
- `FRAMER_TLAST_CHECK_EN` undefined:
  - `s_axis_tlast` is unused.
  - `err_tlast` is tied to 0.

## Structure
- Shared package `sr_axis_pkg`:
  - `pixel_t` (DATA_WIDTH logic vector).
  - `beat_t` struct {pixel_t data; logic last; logic user}.
  - Default DST_IMG_WIDTH/HEIGHT constants.
  - Framer state enum {IDLE, RUN, DRAIN}.
- Sub-module `axis_skid_buffer`, parameterised on `beat_t` width:
  - 2 entries, registered ready.
  - Exposes an `empty` output for the DRAIN exit condition.

## Test plan
Benches use W=4, H=2.
- Basic frame: reset, `frame_start`, 8 beats 0x000001..0x000008 with `m_axis_tready`=1.
  - `tuser`=1 only on 0x000001.
  - `tlast`=1 on 0x000004 and 0x000008.
  - `frame_done` pulses once, 1 cycle after beat 8.
- Backpressure: toggle `m_axis_tready` 1,0,0,1 randomly across the frame.
  - Output order is 1..8 with no loss or duplication.
  - `m_axis_*` is stable during stalls.
  - `s_axis_tready` drops within 1 cycle of the stall.
- Idle gating: drive `s_axis_tvalid`=1 before `frame_start` → `s_axis_tready`=0, no output.
- Mid-frame reset: assert `rst_n`=0 after beat 3.
  - All outputs return to reset values.
  - A following `frame_start` plus 8 beats produces a clean frame with `tuser` on the first beat.
- Ignored re-arm: `frame_start` pulse at beat 5 → counters are unaffected; `tlast` stays on beat 8.
- Check feature (`FRAMER_TLAST_CHECK_EN`): drive `s_axis_tlast`=1 on beat 3.
  - `err_tlast`=1 and stays 1 through `frame_done`.
  - The next `frame_start` clears it.
  - Without the macro, `err_tlast` stays 0.
